// File: rtl/xkrc_stream.sv
// xkrc_stream: per-round keyed word stream, y = X ^ K(round parity) ^ RC, NWORDS words per block.
// Latency: block accepted in WAITX -> first word valid next cycle; one ROTATE bubble per round.
// Backpressure: words hold while y_ready=0; x_ready/key_ready only in WAITX/IDLE. Macro XKRC_STREAM_RC_EN enables RC.
module xkrc_stream #(
    parameter int WORD_W  = 16,
    parameter int NWORDS  = 4,
    parameter int NROUNDS = 10,
    parameter int ROT     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*WORD_W*NWORDS-1:0] key_in,
    input  logic                       key_valid,
    output logic                       key_ready,
    input  logic [WORD_W*NWORDS-1:0]   x_in,
    input  logic                       x_valid,
    output logic                       x_ready,
    output logic [WORD_W-1:0]          y_out,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic                       y_last,
    input  logic                       abort,
    output logic [3:0]                 round_idx,
    output logic                       busy
);
    localparam int BLK = WORD_W * NWORDS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAITX  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_ROTATE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [BLK-1:0] k0_q, k0_d;
    logic [BLK-1:0] k1_q, k1_d;
    logic [BLK-1:0] x_q, x_d;
    logic [3:0]     w_q, w_d;
    logic [3:0]     rnd_q, rnd_d;

    logic [BLK-1:0]    ksel;
    logic [WORD_W-1:0] xw;
    logic [WORD_W-1:0] kw;
    logic [4:0]        rnd_inc;

    function automatic logic [BLK-1:0] rotl(input logic [BLK-1:0] v);
        if (ROT == 0) begin
            return v;
        end else begin
            return (v << ROT) | (v >> (BLK - ROT));
        end
    endfunction

    assign ksel    = rnd_q[0] ? k1_q : k0_q;
    assign rnd_inc = {1'b0, rnd_q} + 5'd1;

    // Next-state logic: abort wins over any handshake in any state.
    always_comb begin
        state_d = state_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        x_d     = x_q;
        w_d     = w_q;
        rnd_d   = rnd_q;
        if (abort) begin
            state_d = S_IDLE;
            w_d     = 4'd0;
            rnd_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_valid) begin
                        k0_d    = key_in[2*BLK-1:BLK];
                        k1_d    = key_in[BLK-1:0];
                        rnd_d   = 4'd0;
                        state_d = S_WAITX;
                    end
                end
                S_WAITX: begin
                    if (x_valid) begin
                        x_d     = x_in;
                        w_d     = 4'd0;
                        state_d = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (y_ready) begin
                        if (w_q == 4'(NWORDS - 1)) begin
                            w_d     = 4'd0;
                            state_d = S_ROTATE;
                        end else begin
                            w_d = w_q + 4'd1;
                        end
                    end
                end
                S_ROTATE: begin
                    // Only the key that served this round is rotated.
                    if (rnd_q[0]) begin
                        k1_d = rotl(k1_q);
                    end else begin
                        k0_d = rotl(k0_q);
                    end
                    if (rnd_inc < 5'(NROUNDS)) begin
                        rnd_d   = rnd_inc[3:0];
                        state_d = S_WAITX;
                    end else begin
                        rnd_d   = 4'd0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers; reset wipes keys and any round in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            x_q     <= '0;
            w_q     <= 4'd0;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            x_q     <= x_d;
            w_q     <= w_d;
            rnd_q   <= rnd_d;
        end
    end

    // Word select: word 0 is the most-significant word of the block and key.
    always_comb begin
        xw = '0;
        kw = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (w_q == 4'(i)) begin
                xw = x_q[(NWORDS-1-i)*WORD_W +: WORD_W];
                kw = ksel[(NWORDS-1-i)*WORD_W +: WORD_W];
            end
        end
    end

`ifdef XKRC_STREAM_RC_EN
    logic [7:0] rc_byte;
    assign rc_byte = {rnd_q, w_q};
    assign y_out   = (state_q == S_STREAM) ? (xw ^ kw ^ WORD_W'(rc_byte)) : '0;
`else
    assign y_out   = (state_q == S_STREAM) ? (xw ^ kw) : '0;
`endif

    assign key_ready = (state_q == S_IDLE);
    assign x_ready   = (state_q == S_WAITX);
    assign y_valid   = (state_q == S_STREAM);
    assign y_last    = (state_q == S_STREAM) && (w_q == 4'(NWORDS - 1));
    assign busy      = (state_q != S_IDLE);
    assign round_idx = rnd_q;

endmodule

// File: tb/tb_xkrc_stream.sv
// Testbench for xkrc_stream: directed vectors, queue-based reference model checked every cycle.
// Latency: checks sampled on negedge (model) and #1 after posedge (directed literals).
// Backpressure: exercises y_ready stalls, abort and reset mid-round; follows XKRC_STREAM_RC_EN.
module tb_xkrc_stream;
    localparam int W   = 16;
    localparam int NW  = 4;
    localparam int NR  = 3;
    localparam int ROT = 5;
    localparam int BLK = W * NW;
`ifdef XKRC_STREAM_RC_EN
    localparam bit RC_EN = 1'b1;
    logic [W-1:0] lit_r0 [NW] = '{16'h0004, 16'h0005, 16'h0006, 16'h0007};
    logic [W-1:0] lit_r1 [NW] = '{16'h0034, 16'h0035, 16'h0036, 16'h0037};
    logic [W-1:0] lit_r2 [NW] = '{16'h0005, 16'h0004, 16'h0007, 16'h0006};
`else
    localparam bit RC_EN = 1'b0;
    logic [W-1:0] lit_r0 [NW] = '{16'h0004, 16'h0004, 16'h0004, 16'h0004};
    logic [W-1:0] lit_r1 [NW] = '{16'h0024, 16'h0024, 16'h0024, 16'h0024};
    logic [W-1:0] lit_r2 [NW] = '{16'h0025, 16'h0025, 16'h0025, 16'h0025};
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2*BLK-1:0] key_in;
    logic             key_valid;
    logic             key_ready;
    logic [BLK-1:0]   x_in;
    logic             x_valid;
    logic             x_ready;
    logic [W-1:0]     y_out;
    logic             y_valid;
    logic             y_ready;
    logic             y_last;
    logic             abort;
    logic [3:0]       round_idx;
    logic             busy;

    int errors = 0;
    int checks = 0;

    xkrc_stream #(.WORD_W(W), .NWORDS(NW), .NROUNDS(NR), .ROT(ROT)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .y_last(y_last),
        .abort(abort), .round_idx(round_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit             m_keyed;
    bit             m_gap;
    int             m_round;
    logic [BLK-1:0] m_k0, m_k1;
    logic [W-1:0]   m_q [$];

    function automatic logic [W-1:0] exp_word(input int r, input int w, input logic [BLK-1:0] x,
                                              input logic [BLK-1:0] k0, input logic [BLK-1:0] k1);
        logic [BLK-1:0] k;
        logic [W-1:0]   rc;
        k  = (r % 2 == 1) ? k1 : k0;
        rc = RC_EN ? W'((r * 16 + w) % 256) : '0;
        return x[BLK-1-w*W -: W] ^ k[BLK-1-w*W -: W] ^ rc;
    endfunction

    function automatic logic [BLK-1:0] rot_model(input logic [BLK-1:0] v);
        logic [BLK-1:0] r;
        r = v;
        for (int i = 0; i < ROT; i++) r = {r[BLK-2:0], r[BLK-1]};
        return r;
    endfunction

    // Compare DUT against the model each cycle, then advance the model with the inputs seen at this edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_keyed = 1'b0; m_gap = 1'b0; m_round = 0; m_q.delete();
            chk(y_out === '0, "rst_y_out", 64'(y_out), 64'h0);
            chk(y_last === 1'b0, "rst_y_last", 64'(y_last), 64'h0);
        end
        chk(key_ready === !m_keyed, "m_key_ready", 64'(key_ready), 64'(!m_keyed));
        chk(x_ready === (m_keyed && m_q.size() == 0 && !m_gap), "m_x_ready", 64'(x_ready),
            64'(m_keyed && m_q.size() == 0 && !m_gap));
        chk(y_valid === (m_q.size() != 0), "m_y_valid", 64'(y_valid), 64'(m_q.size() != 0));
        chk(busy === m_keyed, "m_busy", 64'(busy), 64'(m_keyed));
        chk(round_idx === 4'(m_round), "m_round_idx", 64'(round_idx), 64'(m_round));
        if (m_q.size() != 0) begin
            chk(y_out === m_q[0], "m_y_out", 64'(y_out), 64'(m_q[0]));
            chk(y_last === (m_q.size() == 1), "m_y_last", 64'(y_last), 64'(m_q.size() == 1));
        end
        if (rst_n) begin
            if (abort) begin
                m_keyed = 1'b0; m_gap = 1'b0; m_round = 0; m_q.delete();
            end else if (!m_keyed) begin
                if (key_valid) begin
                    m_k0 = key_in[2*BLK-1:BLK]; m_k1 = key_in[BLK-1:0];
                    m_keyed = 1'b1; m_round = 0;
                end
            end else if (m_gap) begin
                if (m_round % 2 == 1) m_k1 = rot_model(m_k1);
                else                  m_k0 = rot_model(m_k0);
                m_round++;
                if (m_round >= NR) begin m_keyed = 1'b0; m_round = 0; end
                m_gap = 1'b0;
            end else if (m_q.size() != 0) begin
                if (y_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_gap = 1'b1;
                end
            end else if (x_valid) begin
                for (int w = 0; w < NW; w++) m_q.push_back(exp_word(m_round, w, x_in, m_k0, m_k1));
            end
        end
    end

    // ---------------- driver ----------------
    logic [W-1:0] cap  [NW];
    logic         capl [NW];

    localparam logic [2*BLK-1:0] KEY = {64'h0001_0001_0001_0001, 64'h0021_0021_0021_0021};
    localparam logic [BLK-1:0]   XB  = 64'h0005_0005_0005_0005;

    task automatic load_key(input logic [2*BLK-1:0] k);
        int g = 0;
        key_in = k; key_valid = 1'b1;
        while (!key_ready && g < 50) begin @(posedge clk); #1; g++; end
        if (g >= 50) chk(1'b0, "key_timeout", 64'(g), 64'd0);
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic send_x(input logic [BLK-1:0] x);
        int g = 0;
        x_in = x; x_valid = 1'b1;
        while (!x_ready && g < 50) begin @(posedge clk); #1; g++; end
        if (g >= 50) chk(1'b0, "x_timeout", 64'(g), 64'd0);
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    task automatic recv(input int nmax, input int stall_at);
        int n = 0;
        int g = 0;
        logic [W-1:0] held;
        y_ready = 1'b1;
        while (n < nmax && g < 100) begin
            if (y_valid && n == stall_at) begin
                y_ready = 1'b0; held = y_out;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk(y_valid === 1'b1, "stall_valid", 64'(y_valid), 64'd1);
                    chk(y_out === held, "stall_hold", 64'(y_out), 64'(held));
                end
                y_ready = 1'b1; stall_at = -1;
            end
            if (y_valid && y_ready) begin cap[n] = y_out; capl[n] = y_last; n++; end
            @(posedge clk); #1; g++;
        end
        if (n < nmax) chk(1'b0, "recv_timeout", 64'(n), 64'(nmax));
    endtask

    task automatic chk_round(input logic [W-1:0] lit [NW], input string nm);
        for (int i = 0; i < NW; i++) begin
            chk(cap[i] === lit[i], nm, 64'(cap[i]), 64'(lit[i]));
            chk(capl[i] === (i == NW - 1), "lit_y_last", 64'(capl[i]), 64'(i == NW - 1));
        end
    endtask

    task automatic chk_idle(input string nm);
        chk(y_valid === 1'b0, nm, 64'(y_valid), 64'd0);
        chk(busy === 1'b0, nm, 64'(busy), 64'd0);
        chk(key_ready === 1'b1, nm, 64'(key_ready), 64'd1);
        chk(round_idx === 4'd0, nm, 64'(round_idx), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; key_in = '0; key_valid = 1'b0; x_in = '0; x_valid = 1'b0;
        y_ready = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset_state");
        chk(x_ready === 1'b0, "reset_x_ready", 64'(x_ready), 64'd0);
        chk(y_out === '0, "reset_y_out", 64'(y_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three full rounds, the second with a 3-cycle stall on word 1.
        load_key(KEY);
        send_x(XB); recv(NW, -1); chk_round(lit_r0, "round0_word");
        send_x(XB); recv(NW, 1);  chk_round(lit_r1, "round1_word");
        send_x(XB);
        x_in = 64'hffff_0000_ffff_0000; x_valid = 1'b1;   // must be ignored while streaming/idle
        recv(NW, -1); chk_round(lit_r2, "round2_word");
        repeat (2) begin @(posedge clk); #1; end
        chk_idle("done_idle");
        repeat (4) begin @(posedge clk); #1; end
        chk(x_ready === 1'b0, "idle_ignores_x", 64'(x_ready), 64'd0);
        chk_idle("idle_after_x");
        x_valid = 1'b0;

        // Abort during word 2 of round 1, then restart from round 0.
        load_key(KEY);
        send_x(XB); recv(NW, -1);
        send_x(XB); recv(2, -1);
        chk(y_valid === 1'b1, "pre_abort_valid", 64'(y_valid), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_idle("after_abort");
        load_key(KEY);
        send_x(XB); recv(NW, -1); chk_round(lit_r0, "restart_abort_word");

        // Reset during word 2 of round 1, then restart from round 0.
        send_x(XB); recv(2, -1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_idle("after_reset");
        @(posedge clk); #1;
        load_key(KEY);
        send_x(XB); recv(NW, -1); chk_round(lit_r0, "restart_reset_word");
        send_x(XB); recv(NW, -1); chk_round(lit_r1, "restart_r1_word");

        // Abort beats a simultaneous key handshake.
        send_x(XB); recv(NW, -1);
        repeat (2) begin @(posedge clk); #1; end
        key_in = KEY; key_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; abort = 1'b0;
        chk_idle("abort_over_key");

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
